// File: rtl/multicycle_control.sv
// Multicycle MIPS32 control sequencer: steps each instruction through fetch/decode/exec/mem/wb
// and decodes datapath selects and write enables from the current state.
module multicycle_control #(
  parameter logic [5:0]  OP_RTYPE = 6'd0,
  parameter logic [5:0]  OP_BEQ   = 6'd4,
  parameter logic [5:0]  OP_LW    = 6'd35,
  parameter logic [5:0]  OP_SW    = 6'd43,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       MemRe,
  output logic       MemWe,
  output logic       IorD,
  output logic       IRwe,
  output logic       PCwe,
  output logic       PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RFwe,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       fault
);

  // Wait counter only needs to hold 0..TIMEOUT-1; reaching the last value with no ready faults.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_BRANCH,
    S_FAULT
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;

  logic is_rtype;
  logic is_beq;
  logic is_lw;
  logic is_sw;
  logic mem_wait;

  assign is_rtype = (OpCode == OP_RTYPE);
  assign is_beq   = (OpCode == OP_BEQ);
  assign is_lw    = (OpCode == OP_LW);
  assign is_sw    = (OpCode == OP_SW);
  assign mem_wait = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      fault    <= 1'b0;
    end else if (mem_wait) begin
      if (wait_cnt == CNT_LAST) begin
        state    <= S_FAULT;
        wait_cnt <= '0;
        fault    <= 1'b1;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end else begin
      wait_cnt <= '0;
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          if (is_rtype || is_lw || is_sw) state <= S_EXEC;
          else if (is_beq)                state <= S_BRANCH;
          else                            state <= S_FETCH;
        end
        S_EXEC:   state <= is_rtype ? S_WB : S_MEM;
        S_MEM:    state <= is_lw ? S_WB : S_FETCH;
        S_WB:     state <= S_FETCH;
        S_BRANCH: state <= S_FETCH;
        S_FAULT:  state <= S_FAULT;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Outputs follow the state; only the fetch/mem completion strobes and the branch PC write look at inputs.
  always_comb begin
    MemRe      = 1'b0;
    MemWe      = 1'b0;
    IorD       = 1'b0;
    IRwe       = 1'b0;
    PCwe       = 1'b0;
    PCSrc      = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'd0;
    ALUOp      = 2'd0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RFwe       = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state)
      S_FETCH: begin
        MemRe   = 1'b1;
        ALUSrcB = 2'd1;
        IRwe    = mem_ready;
        PCwe    = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB    = 2'd3;
        illegal_op = !(is_rtype || is_beq || is_lw || is_sw);
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        if (is_rtype) begin
          ALUSrcB = 2'd0;
          ALUOp   = 2'd2;
        end else begin
          ALUSrcB = 2'd2;
          ALUOp   = 2'd0;
        end
      end
      S_MEM: begin
        IorD = 1'b1;
        if (is_lw) begin
          MemRe = 1'b1;
        end else begin
          MemWe      = 1'b1;
          instr_done = mem_ready;
        end
      end
      S_WB: begin
        RFwe       = 1'b1;
        RegDst     = is_rtype;
        MemtoReg   = is_lw;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'd0;
        ALUOp      = 2'd1;
        PCwe       = zero;
        PCSrc      = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each instruction class is stepped cycle by cycle
// and the full control word is compared against hand-computed values.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] OpCode;
  logic       mem_ready;
  logic       zero;
  logic       MemRe, MemWe, IorD, IRwe, PCwe, PCSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp;
  logic       RegDst, MemtoReg, RFwe, instr_done, illegal_op, fault;

  int vectors = 0;
  int miscompares = 0;

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .OpCode     (OpCode),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .MemRe      (MemRe),
    .MemWe      (MemWe),
    .IorD       (IorD),
    .IRwe       (IRwe),
    .PCwe       (PCwe),
    .PCSrc      (PCSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .RFwe       (RFwe),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .fault      (fault)
  );

  // Control word field order: MemRe MemWe IorD IRwe PCwe PCSrc ALUSrcA ALUSrcB ALUOp RegDst MemtoReg RFwe done illegal fault
  logic [16:0] outs;
  assign outs = {MemRe, MemWe, IorD, IRwe, PCwe, PCSrc, ALUSrcA, ALUSrcB, ALUOp,
                 RegDst, MemtoReg, RFwe, instr_done, illegal_op, fault};

  localparam logic [16:0] E_FETCH_WAIT = 17'b1_0_0_0_0_0_0_01_00_0_0_0_0_0_0;
  localparam logic [16:0] E_FETCH_RDY  = 17'b1_0_0_1_1_0_0_01_00_0_0_0_0_0_0;
  localparam logic [16:0] E_DECODE     = 17'b0_0_0_0_0_0_0_11_00_0_0_0_0_0_0;
  localparam logic [16:0] E_DECODE_ILL = 17'b0_0_0_0_0_0_0_11_00_0_0_0_0_1_0;
  localparam logic [16:0] E_EXEC_R     = 17'b0_0_0_0_0_0_1_00_10_0_0_0_0_0_0;
  localparam logic [16:0] E_EXEC_M     = 17'b0_0_0_0_0_0_1_10_00_0_0_0_0_0_0;
  localparam logic [16:0] E_MEM_LW     = 17'b1_0_1_0_0_0_0_00_00_0_0_0_0_0_0;
  localparam logic [16:0] E_MEM_SW_W   = 17'b0_1_1_0_0_0_0_00_00_0_0_0_0_0_0;
  localparam logic [16:0] E_MEM_SW_D   = 17'b0_1_1_0_0_0_0_00_00_0_0_0_1_0_0;
  localparam logic [16:0] E_WB_R       = 17'b0_0_0_0_0_0_0_00_00_1_0_1_1_0_0;
  localparam logic [16:0] E_WB_LW      = 17'b0_0_0_0_0_0_0_00_00_0_1_1_1_0_0;
  localparam logic [16:0] E_BR_T       = 17'b0_0_0_0_1_1_1_00_01_0_0_0_1_0_0;
  localparam logic [16:0] E_BR_NT      = 17'b0_0_0_0_0_1_1_00_01_0_0_0_1_0_0;
  localparam logic [16:0] E_FAULT      = 17'b0_0_0_0_0_0_0_00_00_0_0_0_0_0_1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    reset = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (outs !== E_FETCH_WAIT) begin
      miscompares++;
      $display("[TB] FAIL reset got %05h want %05h", outs, E_FETCH_WAIT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype;
    logic [16:0] exp_v [4] = '{E_FETCH_RDY, E_DECODE, E_EXEC_R, E_WB_R};
    OpCode = 6'd0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (outs !== exp_v[i]) begin
        miscompares++;
        $display("[TB] FAIL rtype[%0d] got %05h want %05h", i, outs, exp_v[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw;
    logic [16:0] exp_v [7] = '{E_FETCH_RDY, E_DECODE, E_EXEC_M, E_MEM_LW, E_MEM_LW, E_MEM_LW, E_WB_LW};
    logic [0:6]  rdy = 7'b1110011;
    OpCode = 6'd35;
    for (int i = 0; i < 7; i++) begin
      mem_ready = rdy[i];
      @(negedge clk);
      vectors++;
      if (outs !== exp_v[i]) begin
        miscompares++;
        $display("[TB] FAIL lw[%0d] got %05h want %05h", i, outs, exp_v[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq;
    logic [16:0] exp_v [3];
    OpCode = 6'd4;
    for (int k = 0; k < 2; k++) begin
      zero = (k == 0);
      exp_v = '{E_FETCH_RDY, E_DECODE, (k == 0) ? E_BR_T : E_BR_NT};
      for (int i = 0; i < 3; i++) begin
        mem_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (outs !== exp_v[i]) begin
          miscompares++;
          $display("[TB] FAIL beq_z%0d[%0d] got %05h want %05h", 1 - k, i, outs, exp_v[i]);
        end
        @(posedge clk); #1;
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_sw;
    logic [16:0] exp_v [5] = '{E_FETCH_RDY, E_DECODE, E_EXEC_M, E_MEM_SW_W, E_MEM_SW_D};
    logic [0:4]  rdy = 5'b11101;
    OpCode = 6'd43;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy[i];
      @(negedge clk);
      vectors++;
      if (outs !== exp_v[i]) begin
        miscompares++;
        $display("[TB] FAIL sw[%0d] got %05h want %05h", i, outs, exp_v[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // Fifteen idle fetch cycles sit one short of the watchdog limit, so the instruction must still complete.
  task automatic test_timeout_edge;
    logic [16:0] tail [4] = '{E_FETCH_RDY, E_DECODE, E_EXEC_R, E_WB_R};
    logic [16:0] want;
    OpCode = 6'd0;
    for (int i = 0; i < 19; i++) begin
      mem_ready = (i >= 15);
      want = (i < 15) ? E_FETCH_WAIT : tail[i - 15];
      @(negedge clk);
      vectors++;
      if (outs !== want) begin
        miscompares++;
        $display("[TB] FAIL timeout_edge[%0d] got %05h want %05h", i, outs, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal;
    logic [16:0] exp_v [3] = '{E_FETCH_RDY, E_DECODE_ILL, E_FETCH_WAIT};
    logic [0:2]  rdy = 3'b110;
    OpCode = 6'd2;
    for (int i = 0; i < 3; i++) begin
      mem_ready = rdy[i];
      @(negedge clk);
      vectors++;
      if (outs !== exp_v[i]) begin
        miscompares++;
        $display("[TB] FAIL illegal[%0d] got %05h want %05h", i, outs, exp_v[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid;
    logic [16:0] exp_v [4] = '{E_FETCH_RDY, E_DECODE, E_EXEC_R, E_FETCH_WAIT};
    logic [0:3]  rdy = 4'b1110;
    logic [0:3]  rst = 4'b0010;
    OpCode = 6'd0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = rdy[i];
      reset = rst[i];
      @(negedge clk);
      vectors++;
      if (outs !== exp_v[i]) begin
        miscompares++;
        $display("[TB] FAIL reset_mid[%0d] got %05h want %05h", i, outs, exp_v[i]);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  task automatic test_fault;
    logic [16:0] want;
    reset = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    OpCode = 6'd0;
    for (int i = 0; i < 20; i++) begin
      mem_ready = (i >= 16);
      want = (i < 16) ? E_FETCH_WAIT : E_FAULT;
      @(negedge clk);
      vectors++;
      if (outs !== want) begin
        miscompares++;
        $display("[TB] FAIL fault[%0d] got %05h want %05h", i, outs, want);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (outs !== E_FETCH_WAIT) begin
      miscompares++;
      $display("[TB] FAIL fault_clear got %05h want %05h", outs, E_FETCH_WAIT);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b0;
    zero = 1'b0;
    OpCode = 6'd0;
    test_reset();
    test_rtype();
    test_lw();
    test_beq();
    test_sw();
    test_timeout_edge();
    test_illegal();
    test_reset_mid();
    test_fault();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
